// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART register loader.
// Optional feature macro: UART_LOADER_PARITY_EN (even parity bit per byte).
package uart_loader_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam logic [2:0] CMD_MARKER = 3'b101;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        P_WAIT_CMD,
        P_WAIT_DATA
    } parse_state_t;

    function automatic logic is_cmd_byte(input logic [DATA_W-1:0] b);
        return b[7:5] == CMD_MARKER;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte receiver: start-bit qualification, 8 data bits LSB first, optional parity, stop check.
// Optional feature macro: UART_LOADER_PARITY_EN (expects an even parity bit before stop).
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rx_sync,
    output logic [DATA_W-1:0] o_byte,
    output logic              o_byte_valid,
    output logic              o_byte_err,
    output logic              o_rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t          r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [2:0]         r_bit_idx, w_bit_idx_next;
    logic [DATA_W-1:0]  r_shift, w_shift_next;
    logic               r_rx_prev;
    logic               w_stop_ok;

`ifdef UART_LOADER_PARITY_EN
    logic r_par_err, w_par_err_next;
    assign w_stop_ok = i_rx_sync && !r_par_err;
`else
    assign w_stop_ok = i_rx_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_rx_prev <= 1'b1;
`ifdef UART_LOADER_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_rx_prev <= i_rx_sync;
`ifdef UART_LOADER_PARITY_EN
            r_par_err <= w_par_err_next;
`endif
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        o_byte_valid   = 1'b0;
        o_byte_err     = 1'b0;
`ifdef UART_LOADER_PARITY_EN
        w_par_err_next = r_par_err;
`endif
        case (r_state)
            RX_IDLE: begin
                w_cnt_next = '0;
                if (!i_rx_sync && r_rx_prev) w_state_next = RX_START;
            end
            RX_START: begin
                // Mid-bit re-check rejects glitches shorter than half a bit.
                if (r_cnt == HALF_M1) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = i_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {i_rx_sync, r_shift[DATA_W-1:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
                        w_state_next = RX_PARITY;
`else
                        w_state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_LOADER_PARITY_EN
            RX_PARITY: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next     = '0;
                    w_par_err_next = i_rx_sync != (^r_shift);
                    w_state_next   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next   = '0;
                    o_byte_valid = w_stop_ok;
                    o_byte_err   = !w_stop_ok;
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = RX_IDLE;
            end
        endcase
    end

    assign o_byte    = r_shift;
    assign o_rx_busy = (r_state != RX_IDLE);

endmodule

// File: rtl/uart_reg_loader.sv
// UART command loader: {101xx aaa} command byte then data byte -> one register write pulse.
// Optional feature macro: UART_LOADER_PARITY_EN (even parity per byte, handled in uart_rx_byte).
module uart_reg_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              write_strobe,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              frame_err,
    output logic              busy
);

    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    logic               r_rx_meta, r_rx_sync;
    logic [DATA_W-1:0]  w_byte;
    logic               w_byte_valid, w_byte_err, w_rx_busy;
    parse_state_t       r_state, w_state_next;
    logic [ADDR_W-1:0]  r_pend_addr, w_pend_addr_next;
    logic [ADDR_W-1:0]  r_address, w_address_next;
    logic [DATA_W-1:0]  r_data, w_data_next;
    logic               r_write_strobe, w_write_strobe_next;
    logic               r_frame_err, w_frame_err_next;
    logic [TO_W-1:0]    r_to_cnt;
    logic               w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx_sync    (r_rx_sync),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_byte_err   (w_byte_err),
        .o_rx_busy    (w_rx_busy)
    );

    // Counts only idle cycles in WAIT_DATA; any start edge makes the receiver busy and clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_to_cnt <= '0;
        else if (r_state != P_WAIT_DATA || w_rx_busy) r_to_cnt <= '0;
        else                                          r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = (r_state == P_WAIT_DATA) && !w_rx_busy && (r_to_cnt == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= P_WAIT_CMD;
            r_pend_addr    <= '0;
            r_address      <= '0;
            r_data         <= '0;
            r_write_strobe <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pend_addr    <= w_pend_addr_next;
            r_address      <= w_address_next;
            r_data         <= w_data_next;
            r_write_strobe <= w_write_strobe_next;
            r_frame_err    <= w_frame_err_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_pend_addr_next    = r_pend_addr;
        w_address_next      = r_address;
        w_data_next         = r_data;
        w_write_strobe_next = 1'b0;
        w_frame_err_next    = 1'b0;
        case (r_state)
            P_WAIT_CMD: begin
                if (w_byte_valid) begin
                    if (is_cmd_byte(w_byte)) begin
                        w_pend_addr_next = w_byte[ADDR_W-1:0];
                        w_state_next     = P_WAIT_DATA;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end else if (w_byte_err) begin
                    w_frame_err_next = 1'b1;
                end
            end
            P_WAIT_DATA: begin
                if (w_byte_valid) begin
                    w_write_strobe_next = 1'b1;
                    w_address_next      = r_pend_addr;
                    w_data_next         = w_byte;
                    w_state_next        = P_WAIT_CMD;
                end else if (w_byte_err || w_timeout) begin
                    w_frame_err_next = 1'b1;
                    w_state_next     = P_WAIT_CMD;
                end
            end
            default: w_state_next = P_WAIT_CMD;
        endcase
    end

    assign write_strobe = r_write_strobe;
    assign frame_err    = r_frame_err;
    assign address      = r_address;
    assign data         = r_data;
    assign busy         = w_rx_busy || (r_state == P_WAIT_DATA);

endmodule

// File: tb/tb_uart_reg_loader.sv
// Bench for uart_reg_loader: table of command/data frames plus timeout, glitch and reset sequences.
// Define UART_LOADER_PARITY_EN to make the serial driver append an even parity bit.
module tb_uart_reg_loader;

    localparam int BIT = 87;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       write_strobe;
    logic [2:0] address;
    logic [7:0] data;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ferr_cycle = 0;

    typedef struct {
        bit         is_wr;
        logic [2:0] a;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        bit         send_b1;
        bit         stop1_ok;
        bit         exp_wr;
        bit         exp_fe;
        logic [2:0] exp_a;
        logic [7:0] exp_d;
    } vec_t;
    vec_t vecs[8];

    uart_reg_loader #(.CLKS_PER_BIT(BIT), .TIMEOUT_BITS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .write_strobe (write_strobe),
        .address      (address),
        .data         (data),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest pending expectation.
    logic [2:0] prev_a = '0;
    logic [7:0] prev_d = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_strobe || frame_err) begin
                $display("event t=%0t ws=%0b fe=%0b addr=%0d data=%02h", $time, write_strobe, frame_err, address, data);
                chk("ws_fe_exclusive", {31'd0, write_strobe & frame_err}, 32'd0);
                if (frame_err) ferr_cycle = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: ws=%0b fe=%0b with nothing expected", write_strobe, frame_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_kind_ws", {31'd0, write_strobe}, {31'd0, e.is_wr});
                    if (e.is_wr) begin
                        chk("write_addr", {29'd0, address}, {29'd0, e.a});
                        chk("write_data", {24'd0, data}, {24'd0, e.d});
                    end
                end
            end else if (address !== prev_a || data !== prev_d) begin
                n_checks++;
                n_errors++;
                $display("FAIL hold_outputs: addr %0d->%0d data %02h->%02h without write_strobe", prev_a, address, prev_d, data);
            end
        end
        prev_a = address;
        prev_d = data;
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
        end
`ifdef UART_LOADER_PARITY_EN
        rx = ^b;
        repeat (BIT) @(posedge clk);
`endif
        rx = stop_ok;
        repeat (BIT) @(posedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (BIT) @(posedge clk);
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        e.is_wr = 1'b1; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_fe();
        exp_t e;
        e.is_wr = 1'b0; e.a = '0; e.d = '0;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 3 * BIT && exp_q.size() != 0; i++) @(posedge clk);
        repeat (BIT) @(posedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 8'h3C};
        vecs[1] = '{8'h45, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
        vecs[2] = '{8'hA2, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 8'h7F};
        vecs[3] = '{8'hA3, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00};
        vecs[4] = '{8'hA3, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h10};
        vecs[5] = '{8'hE5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h00};
        vecs[6] = '{8'hBF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 8'hFF};
        vecs[7] = '{8'hB8, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h81};

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_write_strobe", {31'd0, write_strobe}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_address", {29'd0, address}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (BIT) @(posedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].exp_wr) push_wr(vecs[i].exp_a, vecs[i].exp_d);
            if (vecs[i].exp_fe) push_fe();
            send_byte(vecs[i].b0, 1'b1);
            if (vecs[i].send_b1) send_byte(vecs[i].b1, vecs[i].stop1_ok);
            drain($sformatf("vec%0d_drain", i));
            chk($sformatf("vec%0d_busy_idle", i), {31'd0, busy}, 32'd0);
        end

        // Command followed by silence: timeout after 16 bit-times, then a bad-marker byte.
        push_fe();
        send_byte(8'hA1, 1'b1);
        begin
            int t_end;
            t_end = cyc;
            @(negedge clk);
            chk("timeout_busy_wait_data", {31'd0, busy}, 32'd1);
            repeat (17 * BIT) @(posedge clk);
            chk("timeout_window", {31'd0, (ferr_cycle - t_end >= 16 * BIT - 90) && (ferr_cycle - t_end <= 16 * BIT)}, 32'd1);
        end
        push_fe();
        send_byte(8'h55, 1'b1);
        drain("timeout_drain");
        chk("timeout_busy_idle", {31'd0, busy}, 32'd0);

        // Short low glitch: receiver starts, rejects it at mid-bit, no event.
        rx = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (10) @(posedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        chk("glitch_no_event", exp_q.size(), 0);

        // Reset during data bit 4 of the data byte abandons the frame.
        send_byte(8'hA4, 1'b1);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                repeat (5 * BIT + BIT / 2) @(posedge clk);
                rst_n = 1'b0;
            end
        join
        @(negedge clk);
        chk("midrst_address", {29'd0, address}, 32'd0);
        chk("midrst_data", {24'd0, data}, 32'd0);
        chk("midrst_write_strobe", {31'd0, write_strobe}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (BIT) @(posedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        @(negedge clk);
        chk("postrst_address", {29'd0, address}, 32'd0);
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        push_wr(3'd6, 8'h99);
        send_byte(8'hA6, 1'b1);
        send_byte(8'h99, 1'b1);
        drain("postrst_drain");
        chk("postrst_hold_addr", {29'd0, address}, 32'd6);
        chk("postrst_hold_data", {24'd0, data}, 32'h99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
